// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the CORDIC gain-compensation block.
package cordic_pkg;
  localparam int          WORD_W        = 16;
  localparam int          FRAC_W        = 15;
  localparam int          ACC_W         = 2 * WORD_W;
  localparam logic [15:0] K_Q15_DEFAULT = 16'd19898;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cordic_serial_mult.sv
// Serial 16-bit signed x Q1.15 multiplier, one shift-add per i_step, MSB-first over the K bits.
// Result is (acc >>> 15); CORDIC_GAIN_ROUND_EN adds 2^14 first (round half up), else floor.
module cordic_serial_mult
  import cordic_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_operand,
  input  logic              i_step,
  input  logic              i_kbit,
  output logic [WORD_W-1:0] o_result
);

`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (FRAC_W - 1));
`else
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = '0;
`endif

  logic signed [WORD_W-1:0] r_op;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_addend;
  logic signed [ACC_W-1:0]  w_rounded;

  assign w_addend  = i_kbit ? {{WORD_W{r_op[WORD_W-1]}}, r_op} : '0;
  assign w_rounded = r_acc + ROUND_BIAS;
  // |operand * K| < 2^30 for K < 1.0, so the low word of the shifted sum is exact
  assign o_result  = WORD_W'(w_rounded >>> FRAC_W);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_op  <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_op  <= i_operand;
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= (r_acc <<< 1) + w_addend;
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// Scales a rotated CORDIC (x,y) pair by 1/An: 17 cycles strobe-to-data_valid, one-deep pending slot,
// pairs beyond that are dropped and flagged on sticky overrun. Rounding option: CORDIC_GAIN_ROUND_EN.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter logic [WORD_W-1:0] K_Q15 = K_Q15_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_out_rot,
  input  logic [WORD_W-1:0] xprime,
  input  logic [WORD_W-1:0] yprime,
  output logic [WORD_W-1:0] xout,
  output logic [WORD_W-1:0] yout,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  state_t            r_state;
  logic [3:0]        r_step;
  logic              r_pend_vld;
  logic [WORD_W-1:0] r_pend_x;
  logic [WORD_W-1:0] r_pend_y;
  logic [WORD_W-1:0] r_xout;
  logic [WORD_W-1:0] r_yout;
  logic              r_dvld;
  logic              r_ovr;

  logic              w_take_pend;
  logic              w_load;
  logic              w_step;
  logic              w_kbit;
  logic [WORD_W-1:0] w_op_x;
  logic [WORD_W-1:0] w_op_y;
  logic [WORD_W-1:0] w_res_x;
  logic [WORD_W-1:0] w_res_y;

  // In DONE a queued pair wins; a fresh strobe with nothing queued goes straight in.
  assign w_take_pend = (r_state == DONE) && r_pend_vld;
  assign w_load      = ((r_state == IDLE) && data_out_rot) ||
                       ((r_state == DONE) && (r_pend_vld || data_out_rot));
  assign w_op_x      = w_take_pend ? r_pend_x : xprime;
  assign w_op_y      = w_take_pend ? r_pend_y : yprime;
  assign w_step      = (r_state == MULT);
  assign w_kbit      = K_Q15[~r_step];  // bit 15 - step

  cordic_serial_mult u_mult_x (
    .clk       (clk),
    .i_rst     (reset),
    .i_load    (w_load),
    .i_operand (w_op_x),
    .i_step    (w_step),
    .i_kbit    (w_kbit),
    .o_result  (w_res_x)
  );

  cordic_serial_mult u_mult_y (
    .clk       (clk),
    .i_rst     (reset),
    .i_load    (w_load),
    .i_operand (w_op_y),
    .i_step    (w_step),
    .i_kbit    (w_kbit),
    .o_result  (w_res_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_step <= '0;
          if (data_out_rot) r_state <= MULT;
        end
        MULT: begin
          r_step <= r_step + 4'd1;
          if (r_step == 4'd15) r_state <= DONE;
        end
        DONE: begin
          r_step  <= '0;
          r_state <= w_load ? MULT : IDLE;
        end
        default: begin
          r_step  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xout <= '0;
      r_yout <= '0;
      r_dvld <= 1'b0;
    end else begin
      r_dvld <= (r_state == DONE);
      if (r_state == DONE) begin
        r_xout <= w_res_x;
        r_yout <= w_res_y;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_vld <= 1'b0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
      r_ovr      <= 1'b0;
    end else if (r_state == DONE) begin
      // Slot is being drained this cycle, so a strobe here refills it rather than overruns.
      if (r_pend_vld) begin
        r_pend_vld <= data_out_rot;
        if (data_out_rot) begin
          r_pend_x <= xprime;
          r_pend_y <= yprime;
        end
      end
    end else if ((r_state == MULT) && data_out_rot) begin
      if (!r_pend_vld) begin
        r_pend_vld <= 1'b1;
        r_pend_x   <= xprime;
        r_pend_y   <= yprime;
      end else begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign xout       = r_xout;
  assign yout       = r_yout;
  assign data_valid = r_dvld;
  assign busy       = (r_state != IDLE);
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Directed plus random bench for cordic_gain_comp against a transaction-level queue model.
module tb_cordic_gain_comp;
  import cordic_pkg::*;

`ifdef CORDIC_GAIN_ROUND_EN
  localparam longint RND_BIAS   = 16384;
  localparam int     EXP_YM1000 = -607;
`else
  localparam longint RND_BIAS   = 0;
  localparam int     EXP_YM1000 = -608;
`endif
  localparam int LATENCY = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_out_rot = 1'b0;
  logic [15:0] xprime = '0;
  logic [15:0] yprime = '0;
  logic [15:0] xout;
  logic [15:0] yout;
  logic        data_valid;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  cordic_gain_comp dut (
    .clk          (clk),
    .reset        (reset),
    .data_out_rot (data_out_rot),
    .xprime       (xprime),
    .yprime       (yprime),
    .xout         (xout),
    .yout         (yout),
    .data_valid   (data_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_scale(input int op);
    longint p;
    p = longint'(op) * longint'(K_Q15_DEFAULT) + RND_BIAS;
    return int'(p >>> 15);
  endfunction

  // Each accepted pair finishes LATENCY edges after it can start: at its strobe, or when the previous one finishes.
  typedef struct {
    int x;
    int y;
    int done;
  } txn_t;

  txn_t q[$];
  txn_t m_t;
  int   cyc = 0;
  int   exp_x = 0;
  int   exp_y = 0;
  bit   exp_ovr = 1'b0;
  int   pulse_cyc = -100;
  bit   chk_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      exp_x     = 0;
      exp_y     = 0;
      exp_ovr   = 1'b0;
      pulse_cyc = -100;
    end else begin
      cyc++;
      if (q.size() > 0 && q[0].done == cyc) begin
        exp_x     = ref_scale(q[0].x);
        exp_y     = ref_scale(q[0].y);
        pulse_cyc = cyc;
        void'(q.pop_front());
      end
      if (data_out_rot) begin
        if (q.size() < 2) begin
          m_t.x    = int'($signed(xprime));
          m_t.y    = int'($signed(yprime));
          m_t.done = ((q.size() > 0) ? q[$].done : cyc) + LATENCY;
          q.push_back(m_t);
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      #3;
      check_val("data_valid", data_valid, (pulse_cyc == cyc));
      check_val("xout", $signed(xout), exp_x);
      check_val("yout", $signed(yout), exp_y);
      check_val("busy", busy, (q.size() > 0));
      check_val("overrun", overrun, exp_ovr);
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    xprime       = x;
    yprime       = y;
    data_out_rot = 1'b1;
    @(negedge clk);
    data_out_rot = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_val(tag, data_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int n0;
  int p1;
  int p2;

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_xout", $signed(xout), 0);
    check_val("rst_yout", $signed(yout), 0);
    check_val("rst_dv", data_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovr", overrun, 0);
    reset  = 1'b0;
    chk_en = 1'b1;
    idle(2);

    send(16'd1000, -16'sd1000);
    n0 = cyc;
    wait_pulse("a_timeout", p1);
    check_val("a_latency", p1 - n0, LATENCY);
    check_val("a_xout", $signed(xout), 607);
    check_val("a_yout", $signed(yout), EXP_YM1000);
    idle(3);

    send(16'sd32767, -16'sd32768);
    wait_pulse("b_timeout", p1);
    check_val("b_xout", $signed(xout), ref_scale(32767));
    check_val("b_yout", $signed(yout), -19898);
    idle(3);

    send(16'd1234, 16'd4321);
    n0 = cyc;
    idle(3);
    send(-16'sd777, 16'd20000);
    wait_pulse("c1_timeout", p1);
    wait_pulse("c2_timeout", p2);
    check_val("c_first_lat", p1 - n0, LATENCY);
    check_val("c_gap", p2 - p1, LATENCY);
    check_val("c_xout2", $signed(xout), ref_scale(-777));
    check_val("c_ovr", overrun, 0);
    idle(3);

    send(16'd111, 16'd222);
    idle(1);
    send(16'd3333, -16'sd4444);
    idle(1);
    send(16'd5555, 16'd6666);
    wait_pulse("d1_timeout", p1);
    wait_pulse("d2_timeout", p2);
    check_val("d_gap", p2 - p1, LATENCY);
    check_val("d_xout2", $signed(xout), ref_scale(3333));
    check_val("d_yout2", $signed(yout), ref_scale(-4444));
    idle(25);
    check_val("d_ovr_sticky", overrun, 1);

    send(16'd500, -16'sd500);
    idle(7);
    #1 reset = 1'b1;
    #1;
    check_val("e_xout", $signed(xout), 0);
    check_val("e_yout", $signed(yout), 0);
    check_val("e_dv", data_valid, 0);
    check_val("e_busy", busy, 0);
    check_val("e_ovr", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("e_no_dv", data_valid, 0);
    end

    send(16'd2468, 16'd1357);
    n0 = cyc;
    idle(15);
    send(-16'sd9999, 16'd8888);
    p1 = cyc;
    check_val("f_dv1", data_valid, 1);
    check_val("f_lat1", p1 - n0, LATENCY);
    wait_pulse("f2_timeout", p2);
    check_val("f_gap", p2 - p1, LATENCY);
    check_val("f_xout2", $signed(xout), ref_scale(-9999));
    check_val("f_yout2", $signed(yout), ref_scale(8888));
    idle(3);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      data_out_rot = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       xprime = 16'h7FFF;
        1:       xprime = 16'h8000;
        default: xprime = 16'($urandom);
      endcase
      yprime = 16'($urandom);
      reset  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    data_out_rot = 1'b0;
    reset        = 1'b0;
    idle(45);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
